// File: rtl/time_display.sv
// Sequential binary-to-BCD conversion of hour/min/sec into four active-low HEX digit codes.
// Optional field blinking while setting is built only when TIME_DISPLAY_BLINK_EN is defined.
module time_display #(
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       showSec,
    input  logic       set,
    input  logic [1:0] sethms,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;
    state_t state, stateNext;

    logic [4:0] snapHour;
    logic [5:0] snapMin, snapSec;
    logic       snapValid;
    logic [5:0] binReg;
    logic [7:0] bcdReg, bcdAdj, bcdShifted;
    logic [3:0] iterCnt;
    logic [1:0] fieldIdx;
    logic [7:0] hourBcd, minBcd;
    logic [7:0] digitHour, digitMin, digitSec;
    logic [2:0] badField;
    logic       timeChanged, lastIter;
    logic [1:0] leftField, rightField;
    logic [7:0] leftBcd, rightBcd;
    logic       leftBad, rightBad, blankLeft, blankRight, blinkActive;

    function automatic logic [6:0] digitCode(input logic blank, input logic bad, input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h7F;
        endcase
        if (bad)
            code = 7'h3F;
        if (blank)
            code = 7'h7F;
        return code;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstN)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        timeChanged = !snapValid || ({hour, min, sec} != {snapHour, snapMin, snapSec});
        lastIter    = (iterCnt == 4'd5);
        case (state)
            IDLE:    if (timeChanged) stateNext = CONV;
            CONV:    if (lastIter && fieldIdx == 2'd2) stateNext = UPDATE;
            UPDATE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // One double-dabble step: correct nibbles >= 5, then shift the next binary bit in.
    always_comb begin
        bcdAdj[3:0] = (bcdReg[3:0] >= 4'd5) ? bcdReg[3:0] + 4'd3 : bcdReg[3:0];
        bcdAdj[7:4] = (bcdReg[7:4] >= 4'd5) ? bcdReg[7:4] + 4'd3 : bcdReg[7:4];
        bcdShifted  = {bcdAdj[6:0], binReg[5]};
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            snapValid <= 1'b0;
            snapHour  <= '0;
            snapMin   <= '0;
            snapSec   <= '0;
            binReg    <= '0;
            bcdReg    <= '0;
            iterCnt   <= '0;
            fieldIdx  <= '0;
            hourBcd   <= '0;
            minBcd    <= '0;
            digitHour <= '0;
            digitMin  <= '0;
            digitSec  <= '0;
            badField  <= '0;
        end else begin
            case (state)
                IDLE: if (timeChanged) begin
                    snapHour  <= hour;
                    snapMin   <= min;
                    snapSec   <= sec;
                    snapValid <= 1'b1;
                    binReg    <= {1'b0, hour};
                    bcdReg    <= '0;
                    iterCnt   <= '0;
                    fieldIdx  <= '0;
                end
                CONV: if (lastIter) begin
                    iterCnt  <= '0;
                    fieldIdx <= fieldIdx + 2'd1;
                    if (fieldIdx == 2'd0) begin
                        hourBcd <= bcdShifted;
                        binReg  <= snapMin;
                        bcdReg  <= '0;
                    end else if (fieldIdx == 2'd1) begin
                        minBcd <= bcdShifted;
                        binReg <= snapSec;
                        bcdReg <= '0;
                    end else begin
                        bcdReg <= bcdShifted;
                    end
                end else begin
                    bcdReg  <= bcdShifted;
                    binReg  <= {binReg[4:0], 1'b0};
                    iterCnt <= iterCnt + 4'd1;
                end
                UPDATE: begin
                    digitHour <= hourBcd;
                    digitMin  <= minBcd;
                    digitSec  <= bcdReg;
                    badField  <= {snapSec > 6'd59, snapMin > 6'd59, snapHour > 5'd23};
                end
                default: ;
            endcase
        end
    end

`ifdef TIME_DISPLAY_BLINK_EN
    localparam int HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
    logic [31:0] blinkCnt;
    logic        blinkPhase;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else if (blinkCnt == 32'(HALF_PERIOD - 1)) begin
            blinkCnt   <= '0;
            blinkPhase <= !blinkPhase;
        end else begin
            blinkCnt <= blinkCnt + 32'd1;
        end
    end

    assign blinkActive = set && blinkPhase;
`else
    localparam int unusedClkHz   = CLK_HZ;
    localparam int unusedBlinkHz = BLINK_HZ;
    logic unusedSet;
    assign unusedSet   = set;
    assign blinkActive = 1'b0;
`endif

    // Field indices match the sethms encoding: 0 hour, 1 min, 2 sec.
    always_comb begin
        leftField  = showSec ? 2'd1 : 2'd0;
        rightField = showSec ? 2'd2 : 2'd1;
        leftBcd    = showSec ? digitMin : digitHour;
        rightBcd   = showSec ? digitSec : digitMin;
        leftBad    = badField[leftField];
        rightBad   = badField[rightField];
        blankLeft  = blinkActive && (sethms == leftField);
        blankRight = blinkActive && (sethms == rightField);
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            hex3 <= 7'h7F;
            hex2 <= 7'h7F;
            hex1 <= 7'h7F;
            hex0 <= 7'h7F;
        end else begin
            hex3 <= digitCode(blankLeft, leftBad, leftBcd[7:4]);
            hex2 <= digitCode(blankLeft, leftBad, leftBcd[3:0]);
            hex1 <= digitCode(blankRight, rightBad, rightBcd[7:4]);
            hex0 <= digitCode(blankRight, rightBad, rightBcd[3:0]);
        end
    end
endmodule

// File: tb/tb_time_display.sv
// Self-checking bench for time_display: directed and random time values against a decimal display model.
module tb_time_display;
    localparam int CLK_HZ   = 8;
    localparam int BLINK_HZ = 1;
`ifdef TIME_DISPLAY_BLINK_EN
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
`endif

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [4:0] hour = '0;
    logic [5:0] min = '0;
    logic [5:0] sec = '0;
    logic       showSec = 1'b0;
    logic       set = 1'b0;
    logic [1:0] sethms = 2'b11;
    logic [6:0] hex3, hex2, hex1, hex0;
    logic       busy;
    logic [27:0] shown;

    int errors = 0;
    int checks = 0;
    int edgesSinceReset = 0;
    int dispH = 0, dispM = 0, dispS = 0;
    logic [6:0] segTable [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    time_display #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
        .clk(clk), .rstN(rstN), .hour(hour), .min(min), .sec(sec),
        .showSec(showSec), .set(set), .sethms(sethms),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .busy(busy)
    );

    always #5 clk = ~clk;
    assign shown = {hex3, hex2, hex1, hex0};

    function automatic logic [13:0] fieldCodes(input int v, input int limit, input bit blank);
        if (blank) return {7'h7F, 7'h7F};
        if (v > limit) return {7'h3F, 7'h3F};
        return {segTable[v / 10], segTable[v % 10]};
    endfunction

    function automatic logic [27:0] expDisp(input int h, input int m, input int s, input bit ss,
                                            input bit blankL, input bit blankR);
        if (ss) return {fieldCodes(m, 59, blankL), fieldCodes(s, 59, blankR)};
        return {fieldCodes(h, 23, blankL), fieldCodes(m, 59, blankR)};
    endfunction

    function automatic bit blinkOn();
`ifdef TIME_DISPLAY_BLINK_EN
        return set && (((edgesSinceReset - 1) / HALF) % 2 == 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rstN) edgesSinceReset++;
        else edgesSinceReset = 0;
    endtask

    task automatic applyStimulus(input int h, input int m, input int s, input bit ss);
        hour    = 5'(h);
        min     = 6'(m);
        sec     = 6'(s);
        showSec = ss;
    endtask

    // Next edge captures the driven time; busy must last 19 cycles and the display update one cycle later.
    task automatic runConversion(input string tag);
        int busyCycles = 0;
        tick();
        while (busy === 1'b1 && busyCycles < 40) begin
            busyCycles++;
            tick();
        end
        checkOutput({tag, " busy cycles"}, 28'(busyCycles), 28'd19);
        checkOutput({tag, " old held"}, shown, expDisp(dispH, dispM, dispS, showSec, 1'b0, 1'b0));
        tick();
        dispH = int'(hour);
        dispM = int'(min);
        dispS = int'(sec);
        checkOutput({tag, " result"}, shown, expDisp(dispH, dispM, dispS, showSec, 1'b0, 1'b0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int h, m, s;
        bit ss;

        applyStimulus(12, 34, 56, 1'b0);
        rstN = 1'b0;
        repeat (3) begin
            tick();
            checkOutput("reset blank", shown, {4{7'h7F}});
        end
        checkOutput("reset busy", 28'(busy), 28'd0);
        rstN = 1'b1;
        runConversion("first 12:34");

        showSec = 1'b1;
        tick();
        checkOutput("mmss switch", shown, expDisp(12, 34, 56, 1'b1, 1'b0, 1'b0));
        checkOutput("mmss no busy", 28'(busy), 28'd0);
        tick();
        checkOutput("mmss still idle", 28'(busy), 28'd0);

        // Change the time again while the first conversion is still running.
        applyStimulus(23, 59, 59, 1'b0);
        tick();
        repeat (5) tick();
        applyStimulus(0, 0, 0, 1'b0);
        repeat (14) tick();
        checkOutput("late change busy low", 28'(busy), 28'd0);
        tick();
        checkOutput("late change first result", shown, expDisp(23, 59, 59, 1'b0, 1'b0, 1'b0));
        checkOutput("late change restart", 28'(busy), 28'd1);
        dispH = 23; dispM = 59; dispS = 59;
        repeat (18) tick();
        checkOutput("second conv busy", 28'(busy), 28'd1);
        tick();
        checkOutput("second conv done", 28'(busy), 28'd0);
        tick();
        checkOutput("second conv 00:00", shown, {4{7'h40}});
        dispH = 0; dispM = 0; dispS = 0;

        applyStimulus(7, 60, 5, 1'b0);
        runConversion("min 60 dash");
        applyStimulus(24, 5, 63, 1'b1);
        runConversion("hour 24 sec 63");

        for (int i = 0; i < 8; i++) begin
            do begin
                h = int'($urandom_range(31, 0));
                m = int'($urandom_range(63, 0));
                s = int'($urandom_range(63, 0));
            end while (h == dispH && m == dispM && s == dispS);
            ss = 1'($urandom_range(1, 0));
            applyStimulus(h, m, s, ss);
            runConversion($sformatf("random %0d", i));
        end

        // Abort a conversion seven cycles in.
        applyStimulus(9, 8, 7, 1'b1);
        tick();
        repeat (6) tick();
        rstN = 1'b0;
        tick();
        checkOutput("abort blank", shown, {4{7'h7F}});
        checkOutput("abort busy", 28'(busy), 28'd0);
        rstN = 1'b1;
        dispH = 0; dispM = 0; dispS = 0;
        runConversion("after abort");

        set = 1'b1;
        sethms = 2'b00;
        showSec = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checkOutput("blink hour", shown, expDisp(dispH, dispM, dispS, 1'b0, blinkOn(), 1'b0));
        end
        sethms = 2'b10;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("sec hidden no blink", shown, expDisp(dispH, dispM, dispS, 1'b0, 1'b0, 1'b0));
        end
        showSec = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("blink sec", shown, expDisp(dispH, dispM, dispS, 1'b1, 1'b0, blinkOn()));
        end
        sethms = 2'b11;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("sethms none", shown, expDisp(dispH, dispM, dispS, 1'b1, 1'b0, 1'b0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
